// File: rtl/trace_pkg.sv
// trace_pkg: shared types and helpers for the pipeline trace tracker.
//
// Holds the record layout carried through the pipeline slots and the retire
// FIFO. The record fields are sized by the TR_* constants below; the top-level
// parameters default to these values and must be kept equal to them.
// No configuration macros are used in this file.
package trace_pkg;

    localparam int TR_NUM_STAGES = 5;
    localparam int TR_ID_W       = 8;
    localparam int TR_PC_W       = 16;
    localparam int TR_CYC_W      = 32;
    localparam int TR_FIFO_DEPTH = 8;

    // One instruction's lifecycle record. stamps[i] is the first cycle the
    // instruction occupied stage i; packed so that stage i sits at
    // bits [i*TR_CYC_W +: TR_CYC_W] of the flattened vector.
    typedef struct packed {
        logic [TR_ID_W-1:0]                      id;
        logic [TR_PC_W-1:0]                      pc;
        logic [TR_NUM_STAGES-1:0][TR_CYC_W-1:0]  stamps;
        logic [7:0]                              stalls;
    } trace_rec_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH-entry synchronous FIFO of trace_rec_t.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write request; accepted when not full, or when full and
//                   a pop happens in the same cycle
//   pop             read request; ignored when empty
//   pop_data        head entry (meaningless while empty)
//   full, empty     occupancy flags, decoded from the registered count
//   count           number of stored entries
// No configuration macros are used in this file.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  trace_rec_t               push_data,
    input  logic                     pop,
    output trace_rec_t               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_rec_t        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Flags come only from the registered count, so nothing on the read
    // side combinationally depends on pop.
    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // When full, the slot being vacated by a same-cycle pop is the one
    // written (wr_ptr == rd_ptr), and the head was already read this cycle.
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_trace_tracker.sv
// pipeline_trace_tracker: follows every fetched instruction through
// NUM_STAGES pipeline stages, timestamps each stage entry, counts stall
// cycles and retires one record per completed instruction into a FIFO.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   fetch_valid/pc       instruction fetched this cycle (ignored while stage 0 holds)
//   stall[i]             stage i holds; also holds every earlier stage
//   flush[i]             kill stage i's contents (beats stall)
//   rec_valid/ready      retire record handshake
//   rec_id/pc/stamp/stalls  head record payload
//   cycle                free-running cycle counter
//   overflow, drop_cnt   sticky drop flag and saturating drop count
//
// Handshake: a record transfers on any rising edge where rec_valid and
// rec_ready are both high. rec_valid comes from registered FIFO state only;
// once high it stays high with a stable payload until the transfer.
//
// Configuration: define TRACE_DISPLAY_EN to print each popped record and a
// warning for each dropped record (simulation only). Port behaviour is the
// same with or without it.
module pipeline_trace_tracker
    import trace_pkg::*;
#(
    parameter int NUM_STAGES = TR_NUM_STAGES,
    parameter int ID_W       = TR_ID_W,
    parameter int PC_W       = TR_PC_W,
    parameter int CYC_W      = TR_CYC_W,
    parameter int FIFO_DEPTH = TR_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_valid,
    input  logic [PC_W-1:0]              fetch_pc,
    input  logic [NUM_STAGES-1:0]        stall,
    input  logic [NUM_STAGES-1:0]        flush,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [ID_W-1:0]              rec_id,
    output logic [PC_W-1:0]              rec_pc,
    output logic [NUM_STAGES*CYC_W-1:0]  rec_stamp,
    output logic [7:0]                   rec_stalls,
    output logic [CYC_W-1:0]             cycle,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);

    localparam int LAST  = NUM_STAGES - 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_STAGES-1:0]  slot_valid;
    logic [NUM_STAGES-1:0]  valid_nxt;
    trace_rec_t             slot     [NUM_STAGES];
    trace_rec_t             slot_nxt [NUM_STAGES];
    logic [NUM_STAGES-1:0]  hold;
    logic [ID_W-1:0]        next_id;
    logic [CYC_W-1:0]       stamp_now;
    trace_rec_t             fetch_rec;
    logic                   fetch_take;

    logic                   retire_push;
    logic                   rec_pop;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   record_dropped;
    trace_rec_t             fifo_head;

    // A stall at stage j freezes stage j and everything upstream of it.
    always_comb begin
        hold = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hold[i] = |(stall >> i);
        end
    end

    // Stage loads stamp the first cycle the instruction will occupy the stage.
    assign stamp_now  = cycle + 1'b1;
    assign fetch_take = fetch_valid && !flush[0] && !hold[0];

    always_comb begin
        fetch_rec           = '0;
        fetch_rec.id        = next_id;
        fetch_rec.pc        = fetch_pc;
        fetch_rec.stamps[0] = stamp_now;
    end

    always_comb begin
        // Stage 0: fed by fetch.
        valid_nxt[0] = slot_valid[0];
        slot_nxt[0]  = slot[0];
        if (flush[0]) begin
            valid_nxt[0] = 1'b0;
        end else if (hold[0]) begin
            if (slot_valid[0]) begin
                slot_nxt[0].stalls = sat_inc8(slot[0].stalls);
            end
        end else begin
            valid_nxt[0] = fetch_valid;
            slot_nxt[0]  = fetch_rec;
        end

        // Later stages: fed by the previous stage. A held or flushed
        // predecessor hands over a bubble, so nothing is duplicated and a
        // killed instruction never moves on.
        for (int i = 1; i < NUM_STAGES; i++) begin
            valid_nxt[i] = slot_valid[i];
            slot_nxt[i]  = slot[i];
            if (flush[i]) begin
                valid_nxt[i] = 1'b0;
            end else if (hold[i]) begin
                if (slot_valid[i]) begin
                    slot_nxt[i].stalls = sat_inc8(slot[i].stalls);
                end
            end else begin
                valid_nxt[i]           = slot_valid[i-1] && !hold[i-1] && !flush[i-1];
                slot_nxt[i]            = slot[i-1];
                slot_nxt[i].stamps[i]  = stamp_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            next_id    <= '0;
            cycle      <= '0;
        end else begin
            slot_valid <= valid_nxt;
            cycle      <= cycle + 1'b1;
            if (fetch_take) begin
                next_id <= next_id + 1'b1;
            end
        end
    end

    // Payload is only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            slot[i] <= slot_nxt[i];
        end
    end

    // Retire: the last stage leaves the pipeline at this edge.
    assign retire_push    = slot_valid[LAST] && !hold[LAST] && !flush[LAST];
    assign rec_valid      = !fifo_empty;
    assign rec_pop        = rec_valid && rec_ready;
    assign fifo_push      = retire_push && (!fifo_full || rec_pop);
    // A drop needs the FIFO at capacity with nothing leaving this cycle.
    assign record_dropped = retire_push && !rec_pop && (fifo_count == CNT_W'(FIFO_DEPTH));

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (slot[LAST]),
        .pop       (rec_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (record_dropped) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    assign rec_id     = fifo_head.id;
    assign rec_pc     = fifo_head.pc;
    assign rec_stamp  = fifo_head.stamps;
    assign rec_stalls = fifo_head.stalls;

`ifdef TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (!rst && rec_pop) begin
            $write("trace: id=%0d pc=%0h stamps=", rec_id, rec_pc);
            for (int i = 0; i < NUM_STAGES; i++) begin
                $write("%0d ", fifo_head.stamps[i]);
            end
            $display("stalls=%0d cycle=%0d fifo_count=%0d", rec_stalls, cycle, fifo_count);
        end
        if (!rst && record_dropped) begin
            $display("trace warning: record id=%0d pc=%0h dropped at cycle %0d",
                     slot[LAST].id, slot[LAST].pc, cycle);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// Directed bench for pipeline_trace_tracker with default parameters
// (5 stages, 8-bit ids, 16-bit PCs, 32-bit cycles, 8-entry FIFO).
// Inputs change 1 time unit after each rising edge; outputs are observed in
// that same window, so each window is one "cycle" as counted by the DUT.
module tb_pipeline_trace_tracker;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_valid;
    logic [15:0]   fetch_pc;
    logic [4:0]    stall;
    logic [4:0]    flush;
    logic          rec_valid;
    logic          rec_ready;
    logic [7:0]    rec_id;
    logic [15:0]   rec_pc;
    logic [159:0]  rec_stamp;
    logic [7:0]    rec_stalls;
    logic [31:0]   cycle;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    pipeline_trace_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .stall       (stall),
        .flush       (flush),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_id      (rec_id),
        .rec_pc      (rec_pc),
        .rec_stamp   (rec_stamp),
        .rec_stalls  (rec_stalls),
        .cycle       (cycle),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input int e_id, input int e_pc,
                             input int s0, input int s1, input int s2, input int s3,
                             input int s4, input int e_st);
        chk({tag, ".valid"},  160'(rec_valid),  160'(1));
        chk({tag, ".id"},     160'(rec_id),     160'(e_id));
        chk({tag, ".pc"},     160'(rec_pc),     160'(e_pc));
        chk({tag, ".stamp"},  rec_stamp,        {32'(s4), 32'(s3), 32'(s2), 32'(s1), 32'(s0)});
        chk({tag, ".stalls"}, 160'(rec_stalls), 160'(e_st));
    endtask

    // Leaves the bench in the window of cycle 0 with all inputs idle.
    task automatic do_reset();
        rst         = 1'b1;
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        stall       = '0;
        flush       = '0;
        rec_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // ---- reset state and single instruction latency ----
        do_reset();
        chk("reset.rec_valid", 160'(rec_valid), 160'(0));
        chk("reset.overflow",  160'(overflow),  160'(0));
        chk("reset.drop_cnt",  160'(drop_cnt),  160'(0));
        chk("reset.cycle",     160'(cycle),     160'(0));
        repeat (3) step();
        chk("t1.cycle3", 160'(cycle), 160'(3));
        fetch_valid = 1'b1;
        fetch_pc    = 16'h0010;
        step();
        fetch_valid = 1'b0;
        repeat (4) step();
        chk("t1.not_yet", 160'(rec_valid), 160'(0));
        step();
        check_rec("t1.rec", 0, 'h10, 4, 5, 6, 7, 8, 0);
        chk("t1.cycle9", 160'(cycle), 160'(9));
        rec_ready = 1'b1;
        step();
        chk("t1.popped", 160'(rec_valid), 160'(0));

        // ---- stall[1] for two cycles while id 1 sits in decode ----
        do_reset();
        rec_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            fetch_valid = (c <= 5);
            fetch_pc    = (c <= 2) ? 16'(16'h0100 + 4 * c) : 16'h010C;
            stall       = (c == 3 || c == 4) ? 5'b00010 : 5'b00000;
            if (c == 6)  check_rec("t2.id0", 0, 'h100, 1, 2, 3, 4, 5, 0);
            if (c == 7)  chk("t2.bubble7", 160'(rec_valid), 160'(0));
            if (c == 8)  chk("t2.bubble8", 160'(rec_valid), 160'(0));
            if (c == 9)  check_rec("t2.id1", 1, 'h104, 2, 3, 6, 7, 8, 2);
            if (c == 10) check_rec("t2.id2", 2, 'h108, 3, 6, 7, 8, 9, 2);
            if (c == 11) check_rec("t2.id3", 3, 'h10C, 6, 7, 8, 9, 10, 0);
            if (c == 12) chk("t2.empty", 160'(rec_valid), 160'(0));
            step();
        end

        // ---- flush beats stall; killed ids never retire ----
        do_reset();
        rec_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            fetch_valid = (c <= 3);
            fetch_pc    = (c <= 2) ? 16'(16'h0200 + 4 * c) : 16'h0208;
            stall       = (c == 2) ? 5'b00010 : 5'b00000;
            flush       = (c == 2) ? 5'b00011 : 5'b00000;
            if (c >= 3 && c <= 8) chk("t3.no_rec", 160'(rec_valid), 160'(0));
            if (c == 9)  check_rec("t3.id2", 2, 'h208, 4, 5, 6, 7, 8, 0);
            if (c == 10) chk("t3.empty", 160'(rec_valid), 160'(0));
            step();
        end

        // ---- overflow: 10 retirements into 8 entries with no consumer ----
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            fetch_valid = (c < 10);
            fetch_pc    = 16'(16'h0300 + c);
            if (c == 13) begin
                chk("t4.ovf13",  160'(overflow), 160'(0));
                chk("t4.drop13", 160'(drop_cnt), 160'(0));
            end
            if (c == 14) begin
                chk("t4.ovf14",  160'(overflow), 160'(1));
                chk("t4.drop14", 160'(drop_cnt), 160'(1));
            end
            step();
        end
        chk("t4.ovf15",  160'(overflow), 160'(1));
        chk("t4.drop15", 160'(drop_cnt), 160'(2));
        for (int k = 0; k < 8; k++) begin
            check_rec("t4.drain", k, 'h300 + k, k + 1, k + 2, k + 3, k + 4, k + 5, 0);
            rec_ready = 1'b1;
            step();
        end
        chk("t4.drained", 160'(rec_valid), 160'(0));
        chk("t4.sticky",  160'(overflow),  160'(1));
        chk("t4.dropfin", 160'(drop_cnt),  160'(2));

        // ---- full FIFO with simultaneous push and pop ----
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            fetch_valid = (c < 9);
            fetch_pc    = 16'(16'h0400 + c);
            step();
        end
        check_rec("t5.head0", 0, 'h400, 1, 2, 3, 4, 5, 0);
        rec_ready = 1'b1;
        step();
        rec_ready = 1'b0;
        chk("t5.ovf",  160'(overflow), 160'(0));
        chk("t5.drop", 160'(drop_cnt), 160'(0));
        for (int k = 1; k <= 8; k++) begin
            check_rec("t5.drain", k, 'h400 + k, k + 1, k + 2, k + 3, k + 4, k + 5, 0);
            rec_ready = 1'b1;
            step();
        end
        chk("t5.drained", 160'(rec_valid), 160'(0));

        // ---- id wrap over 300 fetches, then reset mid-stream ----
        do_reset();
        rec_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 16'(c);
            if (c == 261) check_rec("t6.id255", 255, 255, 256, 257, 258, 259, 260, 0);
            if (c == 262) check_rec("t6.wrap0", 0, 256, 257, 258, 259, 260, 261, 0);
            step();
        end
        chk("t6.busy", 160'(rec_valid), 160'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6.rst_valid", 160'(rec_valid), 160'(0));
        chk("t6.rst_cycle", 160'(cycle),     160'(0));
        for (int c = 0; c <= 6; c++) begin
            fetch_valid = 1'b1;
            fetch_pc    = 16'(16'h0500 + c);
            if (c == 5) chk("t6.pre_first", 160'(rec_valid), 160'(0));
            if (c == 6) check_rec("t6.first", 0, 'h500, 1, 2, 3, 4, 5, 0);
            step();
        end
        fetch_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
